// File: rtl/core_bus_buffer.sv
// Request FIFO between the Core bus port and the system bus. It caps the number of
// reads in flight by counting completed response bursts; responses pass straight through.
module core_bus_buffer #(
  parameter int BUS_DATA_WIDTH  = 64,
  parameter int BUS_TAG_WIDTH   = 13,
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_BEATS      = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   up_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0]              up_req,
  input  logic [BUS_TAG_WIDTH-1:0]               up_reqtag,
  output logic                                   up_reqack,
  output logic                                   dn_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]              dn_req,
  output logic [BUS_TAG_WIDTH-1:0]               dn_reqtag,
  input  logic                                   dn_reqack,
  input  logic                                   dn_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]              dn_resp,
  input  logic [BUS_TAG_WIDTH-1:0]               dn_resptag,
  output logic                                   dn_respack,
  output logic                                   up_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]              up_resp,
  output logic [BUS_TAG_WIDTH-1:0]               up_resptag,
  input  logic                                   up_respack,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;
  localparam int EW = BUS_TAG_WIDTH + BUS_DATA_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] beat_cnt;
  logic [EW-1:0] head;
  logic          head_is_read;
  logic          show_head;
  logic          blocked;
  logic          push;
  logic          pop;
  logic          resp_hs;
  logic          last_beat;
  logic          inc;
  logic          dec;

  assign head         = mem[rd_ptr];
  assign head_is_read = head[EW-1];
  assign show_head    = reset && (count != '0);
  assign blocked      = head_is_read && (outstanding == OW'(MAX_OUTSTANDING));

  assign up_reqack = reset && up_reqcyc && (count != CW'(DEPTH));
  assign dn_reqcyc = show_head && !blocked;
  assign dn_req    = show_head ? head[BUS_DATA_WIDTH-1:0] : '0;
  assign dn_reqtag = show_head ? head[EW-1:BUS_DATA_WIDTH] : '0;

  assign push = up_reqack;
  assign pop  = dn_reqcyc && dn_reqack;

  assign up_respcyc = dn_respcyc;
  assign up_resp    = dn_resp;
  assign up_resptag = dn_resptag;
  assign dn_respack = up_respack;

  assign resp_hs   = dn_respcyc && up_respack;
  assign last_beat = resp_hs && (beat_cnt == BW'(RESP_BEATS - 1));
  assign inc       = pop && head_is_read;
  // A burst completing with nothing outstanding is a protocol error; drop the decrement.
  assign dec       = last_beat && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {up_reqtag, up_req};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (resp_hs) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
      case ({inc, dec})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_buffer.sv
// Directed bench for core_bus_buffer: issued beats go into an expected queue and a
// negedge monitor compares every downstream request handshake against it.
module tb_core_bus_buffer;

  localparam int DW = 64;
  localparam int TW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          up_reqcyc = 1'b0;
  logic [DW-1:0] up_req = '0;
  logic [TW-1:0] up_reqtag = '0;
  logic          up_reqack;
  logic          dn_reqcyc;
  logic [DW-1:0] dn_req;
  logic [TW-1:0] dn_reqtag;
  logic          dn_reqack = 1'b0;
  logic          dn_respcyc = 1'b0;
  logic [DW-1:0] dn_resp = '0;
  logic [TW-1:0] dn_resptag = '0;
  logic          dn_respack;
  logic          up_respcyc;
  logic [DW-1:0] up_resp;
  logic [TW-1:0] up_resptag;
  logic          up_respack = 1'b0;
  logic [1:0]    outstanding;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  core_bus_buffer #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH(TW),
    .DEPTH(8),
    .MAX_OUTSTANDING(2),
    .RESP_BEATS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .up_reqcyc(up_reqcyc),
    .up_req(up_req),
    .up_reqtag(up_reqtag),
    .up_reqack(up_reqack),
    .dn_reqcyc(dn_reqcyc),
    .dn_req(dn_req),
    .dn_reqtag(dn_reqtag),
    .dn_reqack(dn_reqack),
    .dn_respcyc(dn_respcyc),
    .dn_resp(dn_resp),
    .dn_resptag(dn_resptag),
    .dn_respack(dn_respack),
    .up_respcyc(up_respcyc),
    .up_resp(up_resp),
    .up_resptag(up_resptag),
    .up_respack(up_respack),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [TW-1:0] t, input logic [DW-1:0] d, input bit exp_ack);
    step();
    up_reqcyc = 1'b1;
    up_reqtag = t;
    up_req    = d;
    #2;
    chk("up_reqack", 64'(up_reqack), 64'(exp_ack));
    if (exp_ack) exp_q.push_back('{tag: t, data: d});
  endtask

  task automatic resp_beats(input int n);
    for (int b = 0; b < n; b++) begin
      step();
      up_reqcyc  = 1'b0;
      dn_respcyc = 1'b1;
      up_respack = 1'b1;
      dn_resp    = 64'hD00 + 64'(b);
      dn_resptag = 13'h1000 + 13'(b);
    end
    step();
    dn_respcyc = 1'b0;
    up_respack = 1'b0;
    #2;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && dn_reqcyc === 1'b1 && dn_reqack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual=%h/%h expected=none", dn_reqtag, dn_req);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("issue_data", dn_req, e.data);
        chk("issue_tag", 64'(dn_reqtag), 64'(e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a request pending
    up_reqcyc = 1'b1;
    up_req    = 64'hAAA;
    up_reqtag = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      chk("reset_ack", 64'(up_reqack), 64'(0));
      chk("reset_dn_reqcyc", 64'(dn_reqcyc), 64'(0));
      chk("reset_outstanding", 64'(outstanding), 64'(0));
      chk("reset_dn_req", dn_req, 64'(0));
    end
    step();
    reset = 1'b1;
    #2;
    chk("ack_after_release", 64'(up_reqack), 64'(1));
    exp_q.push_back('{tag: 13'h0, data: 64'hAAA});
    step();
    up_reqcyc = 1'b0;
    dn_reqack = 1'b1;
    #2;
    chk("latency_next_cycle", 64'(dn_reqcyc), 64'(1));
    step();
    dn_reqack = 1'b0;
    #2;
    chk("empty_after_drain", 64'(dn_reqcyc), 64'(0));

    // Fill to full with writes, ninth beat refused
    for (int i = 0; i < 9; i++) push_beat(13'h0, 64'h100 + 64'(i), i < 8);
    step();
    dn_reqack = 1'b1;
    #2;
    chk("full_no_ack", 64'(up_reqack), 64'(0));
    chk("full_dn_reqcyc", 64'(dn_reqcyc), 64'(1));
    step();
    #2;
    chk("push_pop_ack", 64'(up_reqack), 64'(1));
    exp_q.push_back('{tag: 13'h0, data: 64'h108});
    for (int k = 2; k < 9; k++) begin
      step();
      up_reqcyc = 1'b0;
      #2;
      chk("throughput", 64'(dn_reqcyc), 64'(1));
    end
    step();
    #2;
    chk("drained", 64'(dn_reqcyc), 64'(0));

    // Outstanding cap: third read blocked at head
    push_beat(13'h1001, 64'h201, 1'b1);
    push_beat(13'h1002, 64'h202, 1'b1);
    push_beat(13'h1003, 64'h203, 1'b1);
    step();
    up_reqcyc = 1'b0;
    #2;
    chk("cap_blocked", 64'(dn_reqcyc), 64'(0));
    chk("cap_outstanding", 64'(outstanding), 64'(2));
    chk("blocked_head_tag", 64'(dn_reqtag), 64'(13'h1003));

    // Response pass-through
    step();
    dn_respcyc = 1'b1;
    dn_resp    = 64'hCAFE_F00D_1234_5678;
    dn_resptag = 13'h1ABC;
    up_respack = 1'b0;
    #2;
    chk("pass_respcyc", 64'(up_respcyc), 64'(1));
    chk("pass_resp", up_resp, 64'hCAFE_F00D_1234_5678);
    chk("pass_resptag", 64'(up_resptag), 64'(13'h1ABC));
    chk("pass_respack", 64'(dn_respack), 64'(0));
    up_respack = 1'b1;
    #1;
    chk("pass_respack_hi", 64'(dn_respack), 64'(1));
    up_respack = 1'b0;
    dn_respcyc = 1'b0;

    // Burst retire: 7 beats do not release, the 8th does
    resp_beats(7);
    chk("seven_beats_no_release", 64'(dn_reqcyc), 64'(0));
    chk("seven_beats_outstanding", 64'(outstanding), 64'(2));
    resp_beats(1);
    chk("retire_outstanding", 64'(outstanding), 64'(1));
    chk("third_read_issues", 64'(dn_reqcyc), 64'(1));
    step();
    #2;
    chk("third_read_counted", 64'(outstanding), 64'(2));

    // Read pop on the same edge as a burst completing
    resp_beats(8);
    chk("one_retired", 64'(outstanding), 64'(1));
    dn_reqack = 1'b0;
    push_beat(13'h1004, 64'h204, 1'b1);
    resp_beats(7);
    chk("read_waiting", 64'(dn_reqcyc), 64'(1));
    step();
    dn_respcyc = 1'b1;
    up_respack = 1'b1;
    dn_reqack  = 1'b1;
    step();
    dn_respcyc = 1'b0;
    up_respack = 1'b0;
    dn_reqack  = 1'b0;
    #2;
    chk("inc_dec_same_edge", 64'(outstanding), 64'(1));

    // Reset mid-burst with a blocked read queued
    dn_reqack = 1'b1;
    push_beat(13'h1005, 64'h205, 1'b1);
    push_beat(13'h1006, 64'h206, 1'b1);
    resp_beats(3);
    chk("pre_reset_outstanding", 64'(outstanding), 64'(2));
    chk("pre_reset_blocked", 64'(dn_reqcyc), 64'(0));
    step();
    reset     = 1'b0;
    up_reqcyc = 1'b1;
    up_req    = 64'h999;
    up_reqtag = 13'h0;
    #2;
    chk("midreset_ack", 64'(up_reqack), 64'(0));
    chk("midreset_dn_reqtag", 64'(dn_reqtag), 64'(0));
    chk("midreset_dn_reqcyc", 64'(dn_reqcyc), 64'(0));
    exp_q.delete();
    step();
    up_reqcyc = 1'b0;
    reset     = 1'b1;
    #2;
    chk("post_reset_outstanding", 64'(outstanding), 64'(0));
    chk("post_reset_empty", 64'(dn_reqcyc), 64'(0));
    chk("post_reset_dn_req", dn_req, 64'(0));

    // Partial-burst count was cleared: a full 8 beats are needed again
    push_beat(13'h1007, 64'h207, 1'b1);
    step();
    up_reqcyc = 1'b0;
    #2;
    chk("fresh_read_issue", 64'(dn_reqcyc), 64'(1));
    step();
    #2;
    chk("fresh_read_counted", 64'(outstanding), 64'(1));
    resp_beats(7);
    chk("beat_cnt_cleared", 64'(outstanding), 64'(1));
    resp_beats(1);
    chk("fresh_burst_retired", 64'(outstanding), 64'(0));
    resp_beats(8);
    chk("saturate_at_zero", 64'(outstanding), 64'(0));

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
